// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared constants and the VVC luma 1/16-phase coefficient table
package interp_pkg;
    localparam int NTAPS  = 8;
    localparam int NFRAC  = 16;
    localparam int FRAC_W = 4;

    typedef logic signed [7:0] coef_t;

    localparam coef_t LUMA_COEF [NFRAC][NTAPS] = '{
        '{ 0, 0,   0, 64,  0,   0, 0,  0},
        '{ 0, 1,  -3, 63,  4,  -2, 1,  0},
        '{-1, 2,  -5, 62,  8,  -3, 1,  0},
        '{-1, 3,  -8, 60, 13,  -4, 1,  0},
        '{-1, 4, -10, 58, 17,  -5, 1,  0},
        '{-1, 4, -11, 52, 26,  -8, 3, -1},
        '{-1, 3,  -9, 47, 31, -10, 4, -1},
        '{-1, 4, -11, 45, 34, -10, 4, -1},
        '{-1, 4, -11, 40, 40, -11, 4, -1},
        '{-1, 4, -10, 34, 45, -11, 4, -1},
        '{-1, 4, -10, 31, 47,  -9, 3, -1},
        '{-1, 3,  -8, 26, 52, -11, 4, -1},
        '{ 0, 1,  -5, 17, 58, -10, 4, -1},
        '{ 0, 1,  -4, 13, 60,  -8, 3, -1},
        '{ 0, 1,  -3,  8, 62,  -5, 2, -1},
        '{ 0, 1,  -2,  4, 63,  -3, 1,  0}
    };
endpackage

// File: rtl/interp_tap_mcm.sv
// rtl/interp_tap_mcm.sv - shift-add constant multipliers for one tap position, phase-selected
module interp_tap_mcm
    import interp_pkg::*;
#(
    parameter int TAP    = 0,
    parameter int DATA_W = 10,
    parameter int ACC_W  = DATA_W + 9
) (
    input  logic [DATA_W-1:0]       x,
    input  logic [FRAC_W-1:0]       frac,
    output logic signed [ACC_W-1:0] prod
);
    // c is an elaboration constant at every call site, so the loop folds to fixed adders
    function automatic logic signed [ACC_W-1:0] shift_add(input logic [DATA_W-1:0] v, input int c);
        logic signed [ACC_W-1:0] xe;
        logic signed [ACC_W-1:0] sum;
        int mag;
        xe  = signed'({{(ACC_W-DATA_W){1'b0}}, v});
        sum = '0;
        mag = (c < 0) ? -c : c;
        for (int b = 0; b < 8; b++) begin
            if (mag[b]) sum = sum + (xe <<< b);
        end
        return (c < 0) ? -sum : sum;
    endfunction

    logic signed [ACC_W-1:0] prod_all [NFRAC];

    for (genvar f = 0; f < NFRAC; f++) begin : g_frac
        assign prod_all[f] = shift_add(x, int'(LUMA_COEF[f][TAP]));
    end

    assign prod = prod_all[frac];
endmodule

// File: rtl/interp_fir8_pipe.sv
// rtl/interp_fir8_pipe.sv - pipelined 8-tap interpolation filter; INTERP_ROUND_CLIP_EN adds round/clip
module interp_fir8_pipe
    import interp_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int ACC_W  = DATA_W + 9,
    parameter int SHIFT  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [FRAC_W-1:0] s_frac,
    input  logic              s_first,
    output logic              m_valid,
    input  logic              m_ready,
`ifdef INTERP_ROUND_CLIP_EN
    output logic [DATA_W-1:0] m_data
`else
    output logic [ACC_W-1:0]  m_data
`endif
);
`ifdef INTERP_ROUND_CLIP_EN
    localparam int OUT_W = DATA_W;
`else
    localparam int OUT_W = ACC_W;
`endif

    if (ACC_W < DATA_W + 9 || SHIFT < 1 || SHIFT >= ACC_W) begin : g_cfg_check
        $error("interp_fir8_pipe: ACC_W must be >= DATA_W+9 and 1 <= SHIFT < ACC_W");
    end

    logic [DATA_W-1:0]       win_q [NTAPS];
    logic [DATA_W-1:0]       win_d [NTAPS];
    logic [3:0]              cnt_q, cnt_d;
    logic [FRAC_W-1:0]       frac_q, frac_d;
    logic                    v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, m_valid_q, m_valid_d;
    logic signed [ACC_W-1:0] prod_c [NTAPS];
    logic signed [ACC_W-1:0] prod_q [NTAPS];
    logic signed [ACC_W-1:0] prod_d [NTAPS];
    logic signed [ACC_W-1:0] sum_q [4];
    logic signed [ACC_W-1:0] sum_d [4];
    logic signed [ACC_W-1:0] acc;
    logic [OUT_W-1:0]        out_c, m_data_q, m_data_d;
    logic                    stall;

    assign stall   = m_valid_q && !m_ready;
    assign s_ready = !stall;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        interp_tap_mcm #(.TAP(k), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_tap (
            .x    (win_q[k]),
            .frac (frac_q),
            .prod (prod_c[k])
        );
    end

    assign acc = sum_q[0] + sum_q[1] + sum_q[2] + sum_q[3];

`ifdef INTERP_ROUND_CLIP_EN
    localparam logic signed [ACC_W-1:0] RND_OFS = ACC_W'(1) <<< (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << DATA_W) - 1);
    logic signed [ACC_W-1:0] rnd;

    assign rnd = (acc + RND_OFS) >>> SHIFT;

    always_comb begin
        out_c = rnd[DATA_W-1:0];
        if (rnd[ACC_W-1])       out_c = '0;
        else if (rnd > OUT_MAX) out_c = '1;
    end
`else
    assign out_c = acc;
`endif

    always_comb begin
        win_d     = win_q;
        cnt_d     = cnt_q;
        frac_d    = frac_q;
        v0_d      = v0_q;
        prod_d    = prod_q;
        v1_d      = v1_q;
        sum_d     = sum_q;
        v2_d      = v2_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (!stall) begin
            v0_d = 1'b0;
            if (s_valid) begin
                // a row start empties the window so the first sample stands alone
                for (int k = 0; k < NTAPS - 1; k++) begin
                    win_d[k] = s_first ? '0 : win_q[k+1];
                end
                win_d[NTAPS-1] = s_data;
                frac_d         = s_frac;
                if (s_first)            cnt_d = 4'd1;
                else if (cnt_q != 4'd8) cnt_d = cnt_q + 4'd1;
                v0_d = (cnt_d == 4'd8);
            end
            prod_d = prod_c;
            v1_d   = v0_q;
            for (int i = 0; i < 4; i++) begin
                sum_d[i] = prod_q[2*i] + prod_q[2*i+1];
            end
            v2_d      = v1_q;
            m_valid_d = v2_q;
            if (v2_q) m_data_d = out_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                win_q[k]  <= '0;
                prod_q[k] <= '0;
            end
            for (int i = 0; i < 4; i++) sum_q[i] <= '0;
            cnt_q     <= '0;
            frac_q    <= '0;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            frac_q    <= frac_d;
            v0_q      <= v0_d;
            prod_q    <= prod_d;
            v1_q      <= v1_d;
            sum_q     <= sum_d;
            v2_q      <= v2_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end
endmodule

// File: tb/tb_interp_fir8_pipe.sv
// tb/tb_interp_fir8_pipe.sv - directed vector bench for interp_fir8_pipe
module tb_interp_fir8_pipe;
    localparam int DATA_W = 10;
    localparam int ACC_W  = 19;
`ifdef INTERP_ROUND_CLIP_EN
    localparam int OUT_W = DATA_W;
`else
    localparam int OUT_W = ACC_W;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic [3:0]        s_frac = '0;
    logic              s_first = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [OUT_W-1:0]  m_data;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    longint got_q[$];
    int     got_cyc[$];

    typedef struct {
        logic [7:0][DATA_W-1:0] x;
        logic [3:0]             frac;
        longint                 acc;
    } vec_t;

    vec_t vecs [7];

    interp_fir8_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_frac  (s_frac),
        .s_first (s_first),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint m_val();
`ifdef INTERP_ROUND_CLIP_EN
        return longint'(m_data);
`else
        return longint'($signed(m_data));
`endif
    endfunction

    function automatic longint exp_out(input longint acc);
`ifdef INTERP_ROUND_CLIP_EN
        longint r;
        r = (acc + 32) >>> 6;
        if (r < 0) r = 0;
        else if (r > 1023) r = 1023;
        return r;
`else
        return acc;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            got_q.push_back(m_val());
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic send(input int d, input int f, input bit first);
        int t;
        bit rdy;
        t = 0;
        s_valid = 1'b1;
        s_data  = DATA_W'(d);
        s_frac  = 4'(f);
        s_first = first;
        forever begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            t++;
            if (t > 50) begin
                check("send timeout", 0, 1);
                break;
            end
        end
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input string name);
        int t;
        t = 0;
        while (got_q.size() < n && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check({name, " count"}, got_q.size(), n);
    endtask

    function automatic vec_t mk(input int x0, input int x1, input int x2, input int x3,
                                input int x4, input int x5, input int x6, input int x7,
                                input int f, input longint acc);
        vec_t v;
        v.x[0] = DATA_W'(x0); v.x[1] = DATA_W'(x1); v.x[2] = DATA_W'(x2); v.x[3] = DATA_W'(x3);
        v.x[4] = DATA_W'(x4); v.x[5] = DATA_W'(x5); v.x[6] = DATA_W'(x6); v.x[7] = DATA_W'(x7);
        v.frac = 4'(f);
        v.acc  = acc;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(1, 2, 3, 4, 5, 6, 7, 8, 0, 256);
        vecs[1] = mk(0, 1023, 0, 1023, 1023, 0, 1023, 0, 8, 90024);
        vecs[2] = mk(0, 0, 1023, 0, 0, 1023, 0, 0, 8, -22506);
        vecs[3] = mk(10, 20, 30, 40, 50, 60, 70, 80, 4, 2710);
        vecs[4] = mk(10, 20, 30, 40, 50, 60, 70, 80, 15, 3160);
        vecs[5] = mk(10, 20, 30, 40, 50, 60, 70, 80, 12, 3050);
        vecs[6] = mk(0, 0, 0, 0, 1023, 1023, 1023, 1023, 8, 32736);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset m_valid", m_valid, 0);
        check("reset m_data", m_val(), 0);
        check("reset s_ready", s_ready, 1);

        // latency: m_valid rises on the third edge after the completing accept
        for (int i = 1; i <= 7; i++) send(i, 0, i == 1);
        send(8, 0, 0);
        check("lat edge0 m_valid", m_valid, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("lat edge2 m_valid", m_valid, 0);
        @(posedge clk);
        #1;
        check("lat edge3 m_valid", m_valid, 1);
        check("lat edge3 m_data", m_val(), exp_out(256));
        wait_outputs(1, "identity");

        for (int r = 0; r < 7; r++) begin
            got_q.delete();
            for (int k = 0; k < 8; k++) send(int'(vecs[r].x[k]), int'(vecs[r].frac), k == 0);
            wait_outputs(1, $sformatf("vec%0d", r));
            if (got_q.size() > 0) check($sformatf("vec%0d data", r), got_q[0], exp_out(vecs[r].acc));
        end

        got_q.delete();
        send(1023, 1, 0);
        wait_outputs(1, "step ninth");
        if (got_q.size() > 0) check("step ninth data", got_q[0], exp_out(67518));

        got_q.delete();
        got_cyc.delete();
        for (int i = 0; i < 12; i++) send(100, 8, i == 0);
        wait_outputs(5, "dc");
        for (int i = 0; i < got_q.size(); i++) check($sformatf("dc data%0d", i), got_q[i], exp_out(6400));
        for (int i = 1; i < got_cyc.size(); i++) check($sformatf("dc spacing%0d", i), got_cyc[i] - got_cyc[i-1], 1);

        got_q.delete();
        fork
            begin
                for (int i = 1; i <= 16; i++) send(i, 0, i == 1);
            end
            begin
                int t;
                longint held;
                t = 0;
                while (!m_valid && t < 100) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                check("bp saw m_valid", m_valid, 1);
                m_ready = 1'b0;
                held = m_val();
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("bp s_ready", s_ready, 0);
                    check("bp m_valid", m_valid, 1);
                    check("bp m_data hold", m_val(), held);
                    @(posedge clk);
                    #1;
                end
                m_ready = 1'b1;
            end
        join
        wait_outputs(9, "bp");
        for (int i = 0; i < got_q.size(); i++) check($sformatf("bp data%0d", i), got_q[i], exp_out(64 * (i + 4)));

        got_q.delete();
        for (int i = 0; i < 8; i++) send(200 + i, 0, i == 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst m_valid", m_valid, 0);
        check("midrst m_data", m_val(), 0);
        check("midrst s_ready", s_ready, 1);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        check("midrst no output", got_q.size(), 0);

        got_q.delete();
        for (int i = 0; i < 5; i++) send(50 + i, 0, i == 0);
        for (int i = 0; i < 7; i++) send(101 + i, 0, i == 0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("restart early count", got_q.size(), 0);
        send(108, 0, 0);
        wait_outputs(1, "restart");
        if (got_q.size() > 0) check("restart data", got_q[0], exp_out(64 * 104));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
